// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and reset constants for the memory arbiter.
//   state_t  : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_t  : which requester owns the outstanding transaction
//   GRANT_I/GRANT_D : bit positions in the one-hot grant vector
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int GRANT_I = 0;
  localparam int GRANT_D = 1;

  localparam state_t RST_STATE = IDLE;
  localparam owner_t RST_OWNER = OWNER_I;
  localparam logic   RST_VALID = 1'b0;

endpackage

// File: rtl/mem_arbiter_grant.sv
// mem_arbiter_grant: picks the winner between the fetch (I) and data (D)
// requesters. Output is a one-hot grant (bit GRANT_I / GRANT_D), all-zero
// when nobody requests.
//   Build option MEMARB_ROUND_ROBIN_EN:
//     defined   - round-robin; last_grant remembers the previous winner and
//                 the other side wins a conflict. Adds clk/rst_n/accept ports.
//     undefined - fixed D-over-I priority, purely combinational.
//   Ports: [clk, rst_n, accept], i_valid, d_valid, grant[1:0]
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
(
`ifdef MEMARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
`endif
  input  logic       i_valid,
  input  logic       d_valid,
  output logic [1:0] grant
);

`ifdef MEMARB_ROUND_ROBIN_EN
  owner_t last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= RST_OWNER;
    end else if (accept) begin
      last_grant <= grant[GRANT_D] ? OWNER_D : OWNER_I;
    end
  end

  always_comb begin
    grant = '0;
    if (i_valid && d_valid) begin
      // Reset value OWNER_I makes D win the first conflict.
      if (last_grant == OWNER_I) grant[GRANT_D] = 1'b1;
      else                       grant[GRANT_I] = 1'b1;
    end else if (d_valid) begin
      grant[GRANT_D] = 1'b1;
    end else if (i_valid) begin
      grant[GRANT_I] = 1'b1;
    end
  end
`else
  always_comb begin
    grant = '0;
    if (d_valid)      grant[GRANT_D] = 1'b1;
    else if (i_valid) grant[GRANT_I] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and
// load/store (D). One transaction outstanding at a time:
//   IDLE  -> accept winner (req_ready high combinationally), latch fields
//   ISSUE -> mem_req_valid held until mem_req_ready
//   WAIT  -> capture mem_rdata on mem_resp_valid, pulse owner's resp_valid
// Build option MEMARB_ROUND_ROBIN_EN selects round-robin arbitration inside
// mem_arbiter_grant; default is fixed D-over-I priority.
// Ports:
//   clk, rst_n (async, active-low)
//   i_req_valid/i_req_ready/i_req_addr, i_resp_valid/i_resp_rdata
//   d_req_valid/d_req_ready/d_req_addr/d_req_wen/d_req_wdata,
//   d_resp_valid/d_resp_rdata
//   mem_req_valid/mem_req_ready/mem_addr/mem_wdata/mem_wen,
//   mem_resp_valid/mem_rdata
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_req_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_resp_rdata,

  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_req_addr,
  input  logic                d_req_wen,
  input  logic [WORD_LEN-1:0] d_req_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_resp_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic                mem_wen,
  input  logic                mem_resp_valid,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  state_t     state_q;
  owner_t     owner_q;
  logic [1:0] grant;
  logic       accept;

  // Accept only from IDLE; readies never look at mem_* inputs.
  assign accept      = (state_q == IDLE) && (i_req_valid || d_req_valid);
  assign i_req_ready = (state_q == IDLE) && grant[GRANT_I];
  assign d_req_ready = (state_q == IDLE) && grant[GRANT_D];

  mem_arbiter_grant u_grant (
`ifdef MEMARB_ROUND_ROBIN_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
`endif
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RST_STATE;
      owner_q       <= RST_OWNER;
      mem_req_valid <= RST_VALID;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wen       <= 1'b0;
      i_resp_valid  <= RST_VALID;
      d_resp_valid  <= RST_VALID;
      i_resp_rdata  <= '0;
      d_resp_rdata  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q       <= ISSUE;
            mem_req_valid <= 1'b1;
            if (grant[GRANT_D]) begin
              owner_q   <= OWNER_D;
              mem_addr  <= d_req_addr;
              mem_wdata <= d_req_wdata;
              mem_wen   <= d_req_wen;
            end else begin
              owner_q   <= OWNER_I;
              mem_addr  <= i_req_addr;
              mem_wdata <= '0;
              mem_wen   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          // Responses outside WAIT are never looked at, so spurious or
          // post-reset stragglers are dropped.
          if (mem_resp_valid) begin
            state_q <= IDLE;
            if (owner_q == OWNER_D) begin
              d_resp_rdata <= mem_rdata;
              d_resp_valid <= 1'b1;
            end else begin
              i_resp_rdata <= mem_rdata;
              i_resp_valid <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_rdata;
  logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // memory model: responds the cycle after a handshake when mem_auto is set
  logic        mem_auto;
  logic        auto_resp = 1'b0;
  logic [31:0] auto_rdata = '0;
  logic        inj_resp;
  logic [31:0] inj_rdata;
  bit   [31:0] wr_arr  [256];
  bit          wr_flag [256];

  assign mem_resp_valid = auto_resp | inj_resp;
  assign mem_rdata      = inj_resp ? inj_rdata : auto_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  // unwritten locations read back as addr ^ 3 (so 0x10 -> 0x13)
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (wr_flag[a[9:2]]) return wr_arr[a[9:2]];
    return a ^ 32'h3;
  endfunction

  always @(posedge clk) begin
    auto_resp <= 1'b0;
    if (mem_auto && mem_req_valid && mem_req_ready) begin
      auto_resp  <= 1'b1;
      auto_rdata <= model_read(mem_addr);
      if (mem_wen) begin
        wr_arr[mem_addr[9:2]]  <= mem_wdata;
        wr_flag[mem_addr[9:2]] <= 1'b1;
      end
    end
  end

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sb_check();
    exp_t e;
    if (i_resp_valid || d_resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("resp_owner", {30'b0, d_resp_valid, i_resp_valid}, e.is_d ? 32'h2 : 32'h1);
        if (e.chk_data)
          check("resp_rdata", e.is_d ? d_resp_rdata : i_resp_rdata, e.data);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic fetch_i(input logic [31:0] a);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    #1;
    check("fetch_i_req_ready_c0", {31'b0, i_req_ready}, 32'h1);
    sb_q.push_back('{1'b0, a ^ 32'h3, 1'b1});
    tick();
    i_req_valid = 1'b0;
    check("fetch_mem_req_valid_c1", {31'b0, mem_req_valid}, 32'h1);
    check("fetch_mem_addr_c1", mem_addr, a);
    check("fetch_mem_wen_c1", {31'b0, mem_wen}, 32'h0);
    check("fetch_mem_wdata_c1", mem_wdata, 32'h0);
    tick();
    check("fetch_i_resp_valid_c2", {31'b0, i_resp_valid}, 32'h0);
    tick();
    check("fetch_i_resp_valid_c3", {31'b0, i_resp_valid}, 32'h1);
    check("fetch_d_resp_valid_c3", {31'b0, d_resp_valid}, 32'h0);
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0;
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_wen = 0; d_req_wdata = '0;
    mem_req_ready = 1'b1; mem_auto = 1'b1;
    inj_resp = 1'b0; inj_rdata = '0;

    // reset state
    tick();
    check("rst_i_req_ready", {31'b0, i_req_ready}, 32'h0);
    check("rst_d_req_ready", {31'b0, d_req_ready}, 32'h0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rst_resp_valids", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_resp_rdata", i_resp_rdata | d_resp_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // single fetch
    fetch_i(32'h10);

    // collision: D wins, I accepted in the d_resp_valid cycle
    i_req_valid = 1; i_req_addr = 32'h10;
    d_req_valid = 1; d_req_addr = 32'h100; d_req_wen = 0;
    #1;
    check("coll_grant", {30'b0, d_req_ready, i_req_ready}, 32'h2);
    sb_q.push_back('{1'b1, 32'h103, 1'b1});
    tick();
    d_req_valid = 0;
    check("coll_mem_addr_d", mem_addr, 32'h100);
    tick();
    tick();
    check("coll_d_resp_valid", {31'b0, d_resp_valid}, 32'h1);
    check("coll_i_ready_same_cycle", {31'b0, i_req_ready}, 32'h1);
    sb_q.push_back('{1'b0, 32'h13, 1'b1});
    tick();
    i_req_valid = 0;
    check("coll_mem_addr_i", mem_addr, 32'h10);
    tick();
    tick();
    check("coll_i_resp_valid", {31'b0, i_resp_valid}, 32'h1);

    // both held valid for 4 transactions
    i_req_valid = 1; i_req_addr = 32'h10;
    d_req_valid = 1; d_req_addr = 32'h100; d_req_wen = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef MEMARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      check("hold_grant", {30'b0, d_req_ready, i_req_ready}, {30'b0, exp_g});
      if (exp_g[1]) sb_q.push_back('{1'b1, 32'h103, 1'b1});
      else          sb_q.push_back('{1'b0, 32'h13, 1'b1});
      tick();
      tick();
      tick();
    end
    i_req_valid = 0;
    d_req_valid = 0;
    tick();

    // store with 2-cycle memory stall
    mem_req_ready = 0;
    d_req_valid = 1; d_req_addr = 32'h20; d_req_wen = 1; d_req_wdata = 32'hDEADBEEF;
    #1;
    check("st_d_req_ready", {31'b0, d_req_ready}, 32'h1);
    sb_q.push_back('{1'b1, 32'h0, 1'b0});
    tick();
    d_req_valid = 0; d_req_wen = 0; d_req_wdata = '0;
    for (int s = 0; s < 3; s++) begin
      if (s == 2) mem_req_ready = 1;
      check("st_mem_req_valid", {31'b0, mem_req_valid}, 32'h1);
      check("st_mem_addr", mem_addr, 32'h20);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_mem_wen", {31'b0, mem_wen}, 32'h1);
      if (s < 2) tick();
    end
    tick();
    check("st_mem_req_valid_done", {31'b0, mem_req_valid}, 32'h0);
    check("st_d_resp_valid_c4", {31'b0, d_resp_valid}, 32'h0);
    tick();
    check("st_d_resp_valid_c5", {31'b0, d_resp_valid}, 32'h1);

    // read back the stored word
    d_req_valid = 1; d_req_addr = 32'h20; d_req_wen = 0;
    #1;
    sb_q.push_back('{1'b1, 32'hDEADBEEF, 1'b1});
    tick();
    d_req_valid = 0;
    tick();
    tick();
    check("ld_back_d_resp_valid", {31'b0, d_resp_valid}, 32'h1);

    // reset while in WAIT, then a late response
    mem_auto = 0;
    i_req_valid = 1; i_req_addr = 32'h44;
    #1;
    check("rw_i_req_ready", {31'b0, i_req_ready}, 32'h1);
    tick();
    i_req_valid = 0;
    tick();
    tick();
    check("rw_in_wait_no_ready", {31'b0, i_req_ready | d_req_ready}, 32'h0);
    rst_n = 0;
    #1;
    check("rw_rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check("rw_rst_mem_addr", mem_addr, 32'h0);
    check("rw_rst_resp_rdata", i_resp_rdata | d_resp_rdata, 32'h0);
    check("rw_rst_resp_valids", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    tick();
    rst_n = 1;
    inj_resp = 1; inj_rdata = 32'hBAD0BAD0;
    tick();
    inj_resp = 0;
    check("rw_late_resp_dropped", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    tick();
    check("rw_late_resp_dropped2", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    mem_auto = 1;
    fetch_i(32'h10);

    // spurious response in IDLE
    inj_resp = 1; inj_rdata = 32'h5A5A5A5A;
    tick();
    inj_resp = 0;
    check("spur_no_resp", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    tick();
    check("spur_no_resp2", {30'b0, d_resp_valid, i_resp_valid}, 32'h0);
    fetch_i(32'h30);

    tick();
    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
